// File: rtl/seg_scan_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Holds the scan FSM state encoding, code width and default blank code.
package seg_scan_pkg;

    localparam int CODE_W = 4;

    localparam logic [CODE_W-1:0] DEF_BLANK_CODE = 4'hF;

    typedef enum logic [1:0] {
        S_OFF,
        S_DRIVE,
        S_GUARD
    } scan_state_t;

endpackage

// File: rtl/seg_scan_if.sv
// Host-side write/commit bus of the scan controller.
// Ports: wr_en, wr_idx, wr_code, commit_req (host->ctrl); commit_pending (ctrl->host).
interface seg_scan_if
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS = 4
);

    logic                          wr_en;
    logic [$clog2(NUM_DIGITS)-1:0] wr_idx;
    logic [CODE_W-1:0]             wr_code;
    logic                          commit_req;
    logic                          commit_pending;

    modport master (
        output wr_en,
        output wr_idx,
        output wr_code,
        output commit_req,
        input  commit_pending
    );

    modport slave (
        input  wr_en,
        input  wr_idx,
        input  wr_code,
        input  commit_req,
        output commit_pending
    );

endinterface

// File: rtl/scan_tick_counter.sv
// Loadable down-counter with terminal-count flag, shared by drive and guard phases.
// Ports: clk, rst_n, i_load, i_load_val, i_dec in; o_tc (count == 0) out.
module scan_tick_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_tc = (r_cnt == '0);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller with double-buffered codes.
// Ports: clk, rst_n, enable in; bus (write/commit, slave); dec_code, digit_sel, frame_tick out.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int                NUM_DIGITS   = 4,
    parameter int                SCAN_DIV     = 1000,
    parameter int                GUARD_CYCLES = 2,
    parameter logic [CODE_W-1:0] BLANK_CODE   = DEF_BLANK_CODE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    seg_scan_if.slave             bus,
    output logic [CODE_W-1:0]     dec_code,
    output logic [NUM_DIGITS-1:0] digit_sel,
    output logic                  frame_tick
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam int CNT_MAX =
        (SCAN_DIV > GUARD_CYCLES) ? SCAN_DIV : GUARD_CYCLES;
    localparam int CNT_W = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] DRV_LD = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] GRD_LD =
        CNT_W'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    scan_state_t r_state;
    scan_state_t w_state_nxt;

    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic [IDX_W-1:0] w_idx_inc;
    logic             w_last;

    logic             w_cnt_load;
    logic             w_cnt_dec;
    logic             w_cnt_tc;
    logic [CNT_W-1:0] w_cnt_ld_val;

    logic w_wrap;
    logic w_swap;
    logic w_wr_ok;
    logic r_pending;

    logic [CODE_W-1:0] r_shadow [NUM_DIGITS];
    logic [CODE_W-1:0] r_active [NUM_DIGITS];
    logic [CODE_W-1:0] w_code_nxt;

    logic [NUM_DIGITS-1:0] r_digit_sel;
    logic [CODE_W-1:0]     r_dec_code;
    logic                  r_frame_tick;

    assign w_last    = (r_idx == LAST_IDX);
    assign w_idx_inc = w_last ? '0 : r_idx + IDX_W'(1);

    scan_tick_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_cnt_load),
        .i_load_val (w_cnt_ld_val),
        .i_dec      (w_cnt_dec),
        .o_tc       (w_cnt_tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_OFF;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_cnt_load   = 1'b0;
        w_cnt_ld_val = '0;
        w_cnt_dec    = 1'b0;
        w_wrap       = 1'b0;
        if (!enable) begin
            w_state_nxt = S_OFF;
            w_idx_nxt   = '0;
            w_cnt_load  = 1'b1;
        end else begin
            unique case (r_state)
                S_OFF: begin
                    w_state_nxt  = S_DRIVE;
                    w_idx_nxt    = '0;
                    w_cnt_load   = 1'b1;
                    w_cnt_ld_val = DRV_LD;
                end
                S_DRIVE: begin
                    w_cnt_dec = 1'b1;
                    if (w_cnt_tc) begin
                        w_cnt_load = 1'b1;
                        if (GUARD_CYCLES == 0) begin
                            w_idx_nxt    = w_idx_inc;
                            w_cnt_ld_val = DRV_LD;
                            w_wrap       = w_last;
                        end else begin
                            w_state_nxt  = S_GUARD;
                            w_cnt_ld_val = GRD_LD;
                        end
                    end
                end
                S_GUARD: begin
                    w_cnt_dec = 1'b1;
                    if (w_cnt_tc) begin
                        w_state_nxt  = S_DRIVE;
                        w_idx_nxt    = w_idx_inc;
                        w_cnt_load   = 1'b1;
                        w_cnt_ld_val = DRV_LD;
                        w_wrap       = w_last;
                    end
                end
                default: begin
                    w_state_nxt = S_OFF;
                    w_idx_nxt   = '0;
                    w_cnt_load  = 1'b1;
                end
            endcase
        end
    end

    // When dark, every edge is a boundary but only an already
    // registered request is honoured; while scanning, a request
    // landing on the wrap edge is satisfied by that same swap.
    assign w_swap = (!enable || r_state == S_OFF)
                  ? r_pending
                  : (w_wrap && (r_pending || bus.commit_req));

    assign w_wr_ok = bus.wr_en &&
        ({1'b0, bus.wr_idx} < (IDX_W + 1)'(NUM_DIGITS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pending <= 1'b0;
        end else if (w_swap) begin
            r_pending <= 1'b0;
        end else if (bus.commit_req) begin
            r_pending <= 1'b1;
        end
    end

    // Swap reads shadow before this edge's write lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                r_shadow[i] <= BLANK_CODE;
                r_active[i] <= BLANK_CODE;
            end
        end else begin
            if (w_swap) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    r_active[i] <= r_shadow[i];
                end
            end
            if (w_wr_ok) begin
                r_shadow[bus.wr_idx] <= bus.wr_code;
            end
        end
    end

    // Outputs are registered from next-state values so the lit
    // digit and its code change together, including on a swap.
    always_comb begin
        w_code_nxt = BLANK_CODE;
        if (w_state_nxt == S_DRIVE) begin
            w_code_nxt = w_swap ? r_shadow[w_idx_nxt]
                                : r_active[w_idx_nxt];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digit_sel  <= '1;
            r_dec_code   <= BLANK_CODE;
            r_frame_tick <= 1'b0;
        end else begin
            r_digit_sel  <= (w_state_nxt == S_DRIVE)
                          ? ~(NUM_DIGITS'(1) << w_idx_nxt)
                          : '1;
            r_dec_code   <= w_code_nxt;
            r_frame_tick <= w_wrap;
        end
    end

    assign digit_sel          = r_digit_sel;
    assign dec_code           = r_dec_code;
    assign frame_tick         = r_frame_tick;
    assign bus.commit_pending = r_pending;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Scoreboard bench for seg_scan_ctrl: one build with a guard cycle, one without.
// Stimulus pushes per-cycle expectations; a monitor pops and compares them.
module tb_seg_scan_ctrl;

    localparam int ND   = 4;
    localparam int SD   = 3;
    localparam int PER0 = ND * (SD + 1);
    localparam int PER1 = ND * SD;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] code0, code1;
    logic [3:0] sel0, sel1;
    logic       tick0, tick1;

    int cyc   = 0;
    int n_vec = 0;
    int n_bad = 0;

    seg_scan_if #(.NUM_DIGITS(ND)) bus0 ();
    seg_scan_if #(.NUM_DIGITS(ND)) bus1 ();

    seg_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .SCAN_DIV     (SD),
        .GUARD_CYCLES (1),
        .BLANK_CODE   (4'hF)
    ) dut0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .bus        (bus0),
        .dec_code   (code0),
        .digit_sel  (sel0),
        .frame_tick (tick0)
    );

    seg_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .SCAN_DIV     (SD),
        .GUARD_CYCLES (0),
        .BLANK_CODE   (4'hF)
    ) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .bus        (bus1),
        .dec_code   (code1),
        .digit_sel  (sel1),
        .frame_tick (tick1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic            on;
        int              t;
        logic            pend;
        logic [3:0][3:0] act;
        logic [3:0][3:0] sh;
    } mdl_t;

    typedef struct packed {
        int         cyc;
        int         dut;
        logic [3:0] sel;
        logic [3:0] code;
        logic       tick;
        logic       pend;
    } exp_t;

    exp_t q[$];
    mdl_t m0, m1;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.on   = 1'b0;
        m.t    = 0;
        m.pend = 1'b0;
        m.act  = 16'hFFFF;
        m.sh   = 16'hFFFF;
        return m;
    endfunction

    // t counts cycles since the scan was switched on; t=0 is the
    // first lit cycle of digit 0 and every multiple of the frame
    // period is a wrap.
    function automatic mdl_t step(
        input mdl_t m, input logic en, input logic we,
        input logic [1:0] wi, input logic [3:0] wc,
        input logic rq, input int per);
        mdl_t n;
        logic swap;
        n = m;
        if (!en || !m.on) begin
            swap = m.pend;
            n.on = en;
            n.t  = 0;
        end else begin
            n.t  = m.t + 1;
            swap = ((n.t % per) == 0) && (m.pend || rq);
        end
        if (swap) begin
            n.act  = m.sh;
            n.pend = 1'b0;
        end else begin
            n.pend = m.pend | rq;
        end
        if (we) n.sh[wi] = wc;
        return n;
    endfunction

    function automatic exp_t outp(input mdl_t m, input int dut,
                                  input int c);
        exp_t e;
        int per, sl, slot, d;
        per    = (dut != 0) ? PER1 : PER0;
        sl     = (dut != 0) ? SD : SD + 1;
        e.cyc  = c;
        e.dut  = dut;
        e.sel  = 4'hF;
        e.code = 4'hF;
        e.tick = 1'b0;
        e.pend = m.pend;
        if (m.on) begin
            slot = m.t % per;
            d    = slot / sl;
            if ((slot % sl) < SD) begin
                e.sel  = ~(4'b0001 << d);
                e.code = m.act[d];
            end
            e.tick = (m.t > 0) && (slot == 0);
        end
        return e;
    endfunction

    task automatic push_both();
        q.push_back(outp(m0, 0, cyc));
        q.push_back(outp(m1, 1, cyc));
    endtask

    task automatic drive_bus(input logic we, input logic [1:0] wi,
                             input logic [3:0] wc, input logic rq);
        bus0.wr_en      = we;
        bus0.wr_idx     = wi;
        bus0.wr_code    = wc;
        bus0.commit_req = rq;
        bus1.wr_en      = we;
        bus1.wr_idx     = wi;
        bus1.wr_code    = wc;
        bus1.commit_req = rq;
    endtask

    task automatic apply(input logic en, input logic we,
                         input logic [1:0] wi, input logic [3:0] wc,
                         input logic rq);
        enable = en;
        drive_bus(we, wi, wc, rq);
        @(negedge clk);
        m0 = step(m0, en, we, wi, wc, rq, PER0);
        m1 = step(m1, en, we, wi, wc, rq, PER1);
        push_both();
    endtask

    task automatic run(input int n);
        repeat (n) apply(1'b1, 1'b0, 2'd0, 4'd0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) apply(1'b0, 1'b0, 2'd0, 4'd0, 1'b0);
    endtask

    task automatic async_reset();
        #2;
        rst_n  = 1'b0;
        enable = 1'b0;
        drive_bus(1'b0, 2'd0, 4'd0, 1'b0);
        m0 = mdl_reset();
        m1 = mdl_reset();
        push_both();
        @(negedge clk);
        push_both();
        rst_n = 1'b1;
    endtask

    task automatic check(input exp_t e);
        logic [3:0] s, c;
        logic       t, p;
        if (e.dut == 0) begin
            s = sel0; c = code0; t = tick0;
            p = bus0.commit_pending;
        end else begin
            s = sel1; c = code1; t = tick1;
            p = bus1.commit_pending;
        end
        n_vec++;
        if (s !== e.sel || c !== e.code ||
            t !== e.tick || p !== e.pend) begin
            n_bad++;
            $display("FAIL cyc%0d dut%0d: got sel=%b code=%h tick=%b pend=%b, want sel=%b code=%h tick=%b pend=%b",
                     e.cyc, e.dut, s, c, t, p,
                     e.sel, e.code, e.tick, e.pend);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk or negedge rst_n);
            #1;
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                e = q.pop_front();
                check(e);
            end
        end
    end

    initial begin
        drive_bus(1'b0, 2'd0, 4'd0, 1'b0);
        m0 = mdl_reset();
        m1 = mdl_reset();
        @(negedge clk);
        push_both();
        rst_n = 1'b1;
        idle(2);

        run(36);

        for (int i = 0; i < 4; i++) begin
            apply(1'b1, 1'b1, 2'(i), 4'(i + 1), 1'b0);
        end
        run(3);
        apply(1'b1, 1'b0, 2'd0, 4'd0, 1'b1);
        apply(1'b1, 1'b0, 2'd0, 4'd0, 1'b1);
        run(34);

        apply(1'b1, 1'b1, 2'd2, 4'd9, 1'b0);
        apply(1'b1, 1'b0, 2'd0, 4'd0, 1'b1);
        for (int k = 0; k < PER0 && ((m0.t + 1) % PER0) != 0; k++)
            run(1);
        apply(1'b1, 1'b1, 2'd2, 4'd7, 1'b0);
        run(20);

        for (int k = 0; k < PER0 && ((m0.t + 1) % PER0) != 0; k++)
            run(1);
        apply(1'b1, 1'b0, 2'd0, 4'd0, 1'b1);
        run(20);

        for (int k = 0; k < PER0 && (m0.t % PER0) != 2 * (SD + 1); k++)
            run(1);
        apply(1'b0, 1'b1, 2'd1, 4'd5, 1'b1);
        idle(3);
        run(40);

        for (int k = 0; k < PER0 && (m0.t % (SD + 1)) != 1; k++)
            run(1);
        async_reset();
        idle(1);
        run(20);
        idle(2);

        @(negedge clk);
        #3;
        if (q.size() != 0) begin
            n_bad += q.size();
            $display("FAIL scoreboard: %0d expectations never checked",
                     q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule
